ray_gen: RTL and testbench

Per-column ray generator sitting directly downstream of the player `controller`.
- Captures the pose the controller publishes: `posX/posY`, `dirX/dirY`, `planeX/planeY` and `valid_out`.
- On each frame-start trigger, sweeps screen columns 0..SCREEN_WIDTH-1.
- For every column, emits the ray direction, the starting map cell and the step signs to the DDA wall-hit stage over a valid/ready handshake.

---
 rtl/raycast_pkg.sv | 27 ++
 rtl/ray_dir_mac.sv | 24 ++
 rtl/ray_gen.sv | 114 +++++++++++
 tb/tb_ray_gen.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/raycast_pkg.sv
// raycast_pkg: fixed-point types, reset pose and camera step shared by the raycaster blocks
package raycast_pkg;
  typedef logic signed [15:0] q8_8_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} ray_state_t;
  typedef struct packed {
    logic [7:0] map_x;
    logic [7:0] map_y;
    q8_8_t dir_x;
    q8_8_t dir_y;
    q8_8_t plane_x;
    q8_8_t plane_y;
  } ray_pose_t;
  localparam logic [15:0] RESET_POS_X = 16'h0C00;
  localparam logic [15:0] RESET_POS_Y = 16'h0000;
  localparam logic [15:0] RESET_DIR_X = 16'h0000;
  localparam logic [15:0] RESET_DIR_Y = 16'h0100;
  localparam logic [15:0] RESET_PLANE_X = 16'h0000;
  localparam logic [15:0] RESET_PLANE_Y = 16'h00A9;
  localparam ray_pose_t RESET_POSE = '{
    map_x: RESET_POS_X[15:8], map_y: RESET_POS_Y[15:8],
    dir_x: RESET_DIR_X, dir_y: RESET_DIR_Y,
    plane_x: RESET_PLANE_X, plane_y: RESET_PLANE_Y
  };
  function automatic int cam_step(input int width);
    return (2 ** 17) / width;
  endfunction
endpackage

// File: rtl/ray_dir_mac.sv
// ray_dir_mac: one lane of dir + (plane*cam >>> 8), two registered stages with a shared stall enable
module ray_dir_mac
  import raycast_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic signed [15:0] dir,
  input  logic signed [15:0] plane,
  input  logic signed [15:0] cam,
  output logic signed [15:0] ray_dir
);
  q8_8_t dir_q, prod_q;
  always_ff @(posedge clk)
    if (rst) begin
      dir_q <= '0;
      prod_q <= '0;
      ray_dir <= '0;
    end else if (en) begin
      dir_q <= dir;
      prod_q <= q8_8_t'((32'(plane) * 32'(cam)) >>> 8);
      ray_dir <= dir_q + prod_q;
    end
endmodule

// File: rtl/ray_gen.sv
// ray_gen: sweeps screen columns on frame start and streams per-column rays to the DDA stage
module ray_gen
  import raycast_pkg::*;
#(
  parameter int SCREEN_WIDTH = 320,
  parameter int N = 24
) (
  input  logic pixel_clk_in,
  input  logic rst_in,
  input  logic pose_valid_in,
  input  logic [15:0] pos_x_in,
  input  logic [15:0] pos_y_in,
  input  logic [15:0] dir_x_in,
  input  logic [15:0] dir_y_in,
  input  logic [15:0] plane_x_in,
  input  logic [15:0] plane_y_in,
  input  logic frame_start_in,
  output logic ray_valid_out,
  input  logic ray_ready_in,
  output logic [$clog2(SCREEN_WIDTH)-1:0] ray_col_out,
  output logic [15:0] ray_dir_x_out,
  output logic [15:0] ray_dir_y_out,
  output logic [7:0] map_x_out,
  output logic [7:0] map_y_out,
  output logic step_x_neg_out,
  output logic step_y_neg_out,
  output logic sweep_done_out,
  output logic overrun_out
);
  localparam int CW = $clog2(SCREEN_WIDTH);
  localparam logic signed [19:0] CAM_INC = 20'(cam_step(SCREEN_WIDTH));
  localparam logic [CW-1:0] LAST_COL = CW'(SCREEN_WIDTH - 1);
  if (N > 256) begin : g_bad_n
    $error("ray_gen: N does not fit the 8-bit map coordinates");
  end
  ray_state_t state;
  ray_pose_t sh, act;
  logic [CW-1:0] col_cnt, s0_col, s1_col;
  logic signed [19:0] cam_acc;
  q8_8_t s0_cam;
  logic s0_v, s1_v, stall;
  logic unused_pos_frac;
  assign unused_pos_frac = ^{pos_x_in[7:0], pos_y_in[7:0]};
  assign stall = ray_valid_out && !ray_ready_in;
  assign step_x_neg_out = ray_dir_x_out[15];
  assign step_y_neg_out = ray_dir_y_out[15];
  always_ff @(posedge pixel_clk_in)
    if (rst_in) begin
      state <= IDLE;
      sh <= RESET_POSE;
      act <= RESET_POSE;
      col_cnt <= '0;
      cam_acc <= '0;
      s0_v <= 1'b0;
      s0_col <= '0;
      s0_cam <= '0;
      s1_v <= 1'b0;
      s1_col <= '0;
      ray_valid_out <= 1'b0;
      ray_col_out <= '0;
      map_x_out <= '0;
      map_y_out <= '0;
      sweep_done_out <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      if (pose_valid_in)
        sh <= '{map_x: pos_x_in[15:8], map_y: pos_y_in[15:8], dir_x: dir_x_in, dir_y: dir_y_in,
                plane_x: plane_x_in, plane_y: plane_y_in};
      sweep_done_out <= 1'b0;
      overrun_out <= frame_start_in && state != IDLE;
      if (!stall) begin
        s0_v <= state == SWEEP;
        s0_col <= col_cnt;
        s0_cam <= q8_8_t'(cam_acc >>> 8);
        s1_v <= s0_v;
        s1_col <= s0_col;
        ray_valid_out <= s1_v;
        if (s1_v) begin
          ray_col_out <= s1_col;
          map_x_out <= act.map_x;
          map_y_out <= act.map_y;
        end
      end
      case (state)
        IDLE:
          if (frame_start_in) begin
            state <= SWEEP;
            act <= sh;
            col_cnt <= '0;
            cam_acc <= -20'sd65536;
          end
        SWEEP:
          if (!stall) begin
            col_cnt <= col_cnt + 1'b1;
            cam_acc <= cam_acc + CAM_INC;
            if (col_cnt == LAST_COL) state <= DRAIN;
          end
        DRAIN:
          if (ray_valid_out && ray_ready_in && !s0_v && !s1_v) begin
            state <= IDLE;
            sweep_done_out <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  ray_dir_mac u_mac_x (
    .clk(pixel_clk_in), .rst(rst_in), .en(!stall),
    .dir(act.dir_x), .plane(act.plane_x), .cam(s0_cam), .ray_dir(ray_dir_x_out)
  );
  ray_dir_mac u_mac_y (
    .clk(pixel_clk_in), .rst(rst_in), .en(!stall),
    .dir(act.dir_y), .plane(act.plane_y), .cam(s0_cam), .ray_dir(ray_dir_y_out)
  );
endmodule

// File: tb/tb_ray_gen.sv
// tb_ray_gen: directed sweeps of ray_gen covering latency, backpressure, pose update, overrun and reset
module tb_ray_gen;
  localparam int W = 320;
  logic clk = 1'b0, rst = 1'b1, pose_valid = 1'b0, frame_start = 1'b0, ready = 1'b1;
  logic [15:0] pos_x, pos_y, dir_x, dir_y, plane_x, plane_y;
  logic ray_valid, step_x_neg, step_y_neg, sweep_done, overrun;
  logic [8:0] ray_col;
  logic [15:0] ray_dx, ray_dy;
  logic [7:0] map_x, map_y;
  logic [15:0] cap_dx[W], cap_dy[W];
  logic [7:0] cap_mx[W], cap_my[W];
  logic cap_sy[W];
  int checks = 0, errors = 0;
  int beats, done_cnt, ovr_cnt, first_valid;

  always #5 clk = ~clk;

  ray_gen #(.SCREEN_WIDTH(W), .N(24)) dut (
    .pixel_clk_in(clk), .rst_in(rst), .pose_valid_in(pose_valid),
    .pos_x_in(pos_x), .pos_y_in(pos_y), .dir_x_in(dir_x), .dir_y_in(dir_y),
    .plane_x_in(plane_x), .plane_y_in(plane_y), .frame_start_in(frame_start),
    .ray_valid_out(ray_valid), .ray_ready_in(ready), .ray_col_out(ray_col),
    .ray_dir_x_out(ray_dx), .ray_dir_y_out(ray_dy), .map_x_out(map_x), .map_y_out(map_y),
    .step_x_neg_out(step_x_neg), .step_y_neg_out(step_y_neg),
    .sweep_done_out(sweep_done), .overrun_out(overrun)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [59:0] outs();
    return {ray_valid, ray_col, ray_dx, ray_dy, map_x, map_y, step_x_neg, step_y_neg};
  endfunction

  function automatic logic [15:0] model_dir(input logic [15:0] d, input logic [15:0] p, input int c);
    logic signed [15:0] ps;
    int cam, prod;
    logic [15:0] r;
    ps = p;
    cam = (-65536 + c * 409) >>> 8;
    prod = ps * cam;
    r = d + prod[23:8];
    return r;
  endfunction

  task automatic sweep(input int mode, input int pose_col, input int ovr_col, input int rst_col,
                       input logic [15:0] edx, input logic [15:0] edy);
    logic [59:0] snap = '0;
    logic stalled = 1'b0, seen57 = 1'b0;
    logic [15:0] ex, ey;
    int hold = 0, n = 0, exp_col = 0, tail = -1;
    beats = 0; done_cnt = 0; ovr_cnt = 0; first_valid = -1;
    frame_start = 1'b1;
    @(negedge clk);
    while (n < 4000 && tail != 0) begin
      frame_start = 1'b0;
      pose_valid = 1'b0;
      if (stalled) check("hold_stable", outs(), snap);
      if (ray_valid && first_valid < 0) first_valid = n;
      done_cnt += int'(sweep_done);
      ovr_cnt += int'(overrun);
      if (sweep_done) check("done_after_last", exp_col, W);
      if (tail > 0) tail--;
      if (sweep_done && tail < 0) tail = 3;
      if (mode == 1 && !seen57 && ray_valid && ray_col == 9'd57) begin
        hold = 10;
        seen57 = 1'b1;
      end
      ready = mode == 0 ? 1'b1 : hold > 0 ? 1'b0 : 1'($urandom_range(0, 1));
      if (hold > 0) hold--;
      if (ray_valid && ready) begin
        ex = model_dir(edx, 16'h0000, exp_col);
        ey = model_dir(edy, 16'h00A9, exp_col);
        check("col", ray_col, exp_col);
        check("dir_x", ray_dx, ex);
        check("dir_y", ray_dy, ey);
        check("map", {map_x, map_y}, 16'h0C00);
        check("step", {step_x_neg, step_y_neg}, {ex[15], ey[15]});
        if (exp_col < W) begin
          cap_dx[exp_col] = ray_dx;
          cap_dy[exp_col] = ray_dy;
          cap_mx[exp_col] = map_x;
          cap_my[exp_col] = map_y;
          cap_sy[exp_col] = step_y_neg;
        end
        if (exp_col == pose_col) begin
          pose_valid = 1'b1;
          dir_x = 16'h0100;
          dir_y = 16'h0000;
        end
        if (exp_col == ovr_col) frame_start = 1'b1;
        if (exp_col == rst_col) begin
          rst = 1'b1;
          @(negedge clk);
          check("rst_mid_outputs", {sweep_done, overrun, outs()}, 62'h0);
          rst = 1'b0;
          return;
        end
        exp_col++;
        beats++;
      end
      stalled = ray_valid && !ready;
      snap = outs();
      @(negedge clk);
      n++;
    end
    ready = 1'b1;
    check("beats", beats, W);
    check("done_pulses", done_cnt, 1);
    check("overrun_pulses", ovr_cnt, ovr_col >= 0 ? 1 : 0);
  endtask

  initial begin
    pos_x = 16'h0C00; pos_y = 16'h0000;
    dir_x = 16'h0000; dir_y = 16'h0100;
    plane_x = 16'h0000; plane_y = 16'h00A9;
    repeat (2) @(negedge clk);
    check("reset_outputs", {sweep_done, overrun, outs()}, 62'h0);
    rst = 1'b0;
    @(negedge clk);
    sweep(0, -1, -1, -1, 16'h0000, 16'h0100);
    check("latency", first_valid, 3);
    check("c0_dir_x", cap_dx[0], 16'h0000);
    check("c0_dir_y", cap_dy[0], 16'h0057);
    check("c0_map", {cap_mx[0], cap_my[0]}, 16'h0C00);
    check("c0_step_y", cap_sy[0], 1'b0);
    check("c160_dir_y", cap_dy[160], 16'h00FF);
    check("c319_dir_y", cap_dy[319], 16'h01A7);
    repeat (3) @(negedge clk);
    sweep(1, 100, 200, -1, 16'h0000, 16'h0100);
    repeat (3) @(negedge clk);
    sweep(0, -1, -1, 150, 16'h0100, 16'h0000);
    check("new_pose_c0_dir_x", cap_dx[0], 16'h0100);
    check("new_pose_c0_dir_y", cap_dy[0], 16'hFF57);
    check("new_pose_c0_step_y", cap_sy[0], 1'b1);
    sweep(0, -1, -1, -1, 16'h0000, 16'h0100);
    check("after_rst_c0_dir_x", cap_dx[0], 16'h0000);
    check("after_rst_c0_dir_y", cap_dy[0], 16'h0057);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
